// File: rtl/uart_fifo_tx_if.sv
// Read-side bundle between a first-word-fall-through FIFO and its consumer.
// master = FIFO side, slave = UART transmit engine.
interface uart_fifo_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_deQ;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_deQ
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_deQ
    );
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmit engine draining a FWFT FIFO onto a single serial line.
// Frame: start, DATA_WIDTH bits LSB first, optional parity, STOP_BITS stops.
module uart_fifo_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 868,
    parameter int CNT_WIDTH  = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    uart_fifo_tx_if.slave   fifo,
    output logic            tx,
    output logic            busy
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(BAUD_DIV - 1);
    localparam logic [IW-1:0]        IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0]        STOP_LAST = IW'(STOP_BITS - 1);

    state_t                state;
    logic [CNT_WIDTH-1:0]  baud_cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  pop;
    logic                  tick;

    // Pop only from IDLE; reset gating keeps the strobe low during reset.
    assign pop  = reset & (state == IDLE) & enable & ~fifo.fifo_empty;
    assign tick = (baud_cnt == CNT_LAST);
    assign fifo.fifo_deQ = pop;

    // Frame sequencer; tx carries the value of the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg    <= fifo.fifo_data;
                        par_bit  <= (PARITY == 1) ? ~^fifo.fifo_data
                                                  : ^fifo.fifo_data;
                        state    <= START;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_WIDTH'(1);
                    end
                end
                PAR: begin
                    if (tick) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_WIDTH'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench: three transmitters (8N1, 8O1, 8E2) at BAUD_DIV=4.
// A FIFO model feeds each; monitors check every line cycle against queues.
`timescale 1ns/1ps
module tb_uart_fifo_tx;
    localparam int BD = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       pb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] en_v;
    logic [2:0] tx_v, busy_v, deq_v, emp_v;
    logic       tx0, tx1, tx2, busy0, busy1, busy2;

    logic [7:0] fq [3][$];
    exp_t       eq [3][$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_fifo_tx_if #(.DATA_WIDTH(8)) f0 ();
    uart_fifo_tx_if #(.DATA_WIDTH(8)) f1 ();
    uart_fifo_tx_if #(.DATA_WIDTH(8)) f2 ();

    uart_fifo_tx #(
        .DATA_WIDTH(8), .BAUD_DIV(BD), .CNT_WIDTH(16),
        .PARITY(0), .STOP_BITS(1)
    ) u0 (
        .clock(clk), .reset(rst_n), .enable(en_v[0]),
        .fifo(f0.slave), .tx(tx0), .busy(busy0)
    );

    uart_fifo_tx #(
        .DATA_WIDTH(8), .BAUD_DIV(BD), .CNT_WIDTH(16),
        .PARITY(1), .STOP_BITS(1)
    ) u1 (
        .clock(clk), .reset(rst_n), .enable(en_v[1]),
        .fifo(f1.slave), .tx(tx1), .busy(busy1)
    );

    uart_fifo_tx #(
        .DATA_WIDTH(8), .BAUD_DIV(BD), .CNT_WIDTH(16),
        .PARITY(2), .STOP_BITS(2)
    ) u2 (
        .clock(clk), .reset(rst_n), .enable(en_v[2]),
        .fifo(f2.slave), .tx(tx2), .busy(busy2)
    );

    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};
    assign deq_v  = {f2.fifo_deQ, f1.fifo_deQ, f0.fifo_deQ};
    assign emp_v  = {f2.fifo_empty, f1.fifo_empty, f0.fifo_empty};

    function automatic int np(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int ns(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s[u%0d] @%0t: got %h want %h",
                     nm, k, $time, act, req);
        end
    endtask

    // Present the FIFO head on the interface of unit k.
    task automatic drive(input int k);
        logic       e;
        logic [7:0] d;
        e = (fq[k].size() == 0);
        d = e ? 8'h00 : fq[k][0];
        case (k)
            0: begin f0.fifo_empty = e; f0.fifo_data = d; end
            1: begin f1.fifo_empty = e; f1.fifo_data = d; end
            default: begin f2.fifo_empty = e; f2.fifo_data = d; end
        endcase
    endtask

    // FWFT FIFO model: pop after a cycle in which deQ was high.
    task automatic fifo_proc(input int k);
        logic p;
        forever begin
            @(negedge clk);
            p = deq_v[k];
            @(posedge clk);
            #1;
            if (p && fq[k].size() > 0)
                void'(fq[k].pop_front());
            drive(k);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic pb);
        exp_t e;
        e.d  = d;
        e.pb = pb;
        fq[k].push_back(d);
        eq[k].push_back(e);
    endtask

    // Monitor: idle-line rules every cycle, full frame check after a pop.
    task automatic mon(input int k);
        exp_t        e;
        logic [11:0] fr;
        int          nb;
        bit          ab;
        forever begin
            @(negedge clk);
            chk("deq", k, 16'(deq_v[k]),
                16'(rst_n & en_v[k] & ~emp_v[k]));
            chk("idle_tx", k, 16'(tx_v[k]), 16'd1);
            chk("idle_busy", k, 16'(busy_v[k]), 16'd0);
            if (deq_v[k] === 1'b1) begin
                if (eq[k].size() == 0) begin
                    chk("sb_unexpected_pop", k, 16'd1, 16'd0);
                end else begin
                    e  = eq[k].pop_front();
                    fr = '1;
                    fr[0]   = 1'b0;
                    fr[8:1] = e.d;
                    if (np(k) != 0) fr[9] = e.pb;
                    nb = 1 + 8 + np(k) + ns(k);
                    ab = 1'b0;
                    for (int b = 0; b < nb && !ab; b++) begin
                        for (int c = 0; c < BD && !ab; c++) begin
                            @(negedge clk);
                            if (!rst_n) begin
                                ab = 1'b1;
                                chk("rst_tx", k, 16'(tx_v[k]), 16'd1);
                                chk("rst_busy", k, 16'(busy_v[k]), 16'd0);
                            end else begin
                                chk("frame_tx", k, 16'(tx_v[k]),
                                    16'(fr[b]));
                                chk("frame_busy", k, 16'(busy_v[k]),
                                    16'd1);
                                chk("frame_deq", k, 16'(deq_v[k]),
                                    16'd0);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        en_v = 3'b000;
        for (int k = 0; k < 3; k++) drive(k);
        #1 rst_n = 1'b0;
        fork
            mon(0); mon(1); mon(2);
            fifo_proc(0); fifo_proc(1); fifo_proc(2);
        join_none
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Single 8N1 frame of 0xA5.
        en_v[0] = 1'b1;
        push(0, 8'hA5, 1'b0);
        cyc(50);

        // Three words back to back, 41-clock spacing.
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        push(0, 8'h03, 1'b0);
        cyc(135);

        // Odd parity (bit 0) and even parity with two stops (bit 1).
        en_v[1] = 1'b1;
        en_v[2] = 1'b1;
        push(1, 8'h07, 1'b0);
        push(2, 8'h07, 1'b1);
        cyc(55);

        // Disabled with data pending, then enable, then drop mid-frame.
        en_v[0] = 1'b0;
        push(0, 8'h3C, 1'b0);
        cyc(30);
        en_v[0] = 1'b1;
        cyc(6);
        push(0, 8'h55, 1'b0);
        en_v[0] = 1'b0;
        cyc(60);
        chk("hold_pending", 0, 16'(fq[0].size()), 16'd1);
        en_v[0] = 1'b1;
        cyc(50);

        // Reset asserted during the data bits of 0xFF.
        push(0, 8'hFF, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (deq_v[0] === 1'b1) seen = 1'b1;
        end
        chk("ff_pop_seen", 0, 16'(seen), 16'd1);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tx", 0, 16'(tx_v[0]), 16'd1);
        chk("async_busy", 0, 16'(busy_v[0]), 16'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(20);

        // Long empty stretch, then one word.
        cyc(100);
        push(0, 8'h96, 1'b0);
        cyc(50);

        for (int k = 0; k < 3; k++)
            chk("sb_drain", k, 16'(eq[k].size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
